// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    SEQ,
    BR,
    J,
    JR
  } pc_src_e;

  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-PC target computation and jr > jump > taken-branch > sequential select.
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_i,
  input  logic        branch_cond_i,
  input  logic [31:0] offset_sh2_i,
  input  logic        jump_i,
  input  logic [25:0] jump_idx_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] next_pc_o,
  output logic        redirect_o
);

  pc_src_e     src;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;

  assign branchTarget = pc_plus4_i + offset_sh2_i;
  assign jumpTarget   = {pc_plus4_i[31:28], jump_idx_i, 2'b00};

  always_comb begin
    src = SEQ;
    if (jr_i) begin
      src = JR;
    end else if (jump_i) begin
      src = J;
    end else if (branch_i && branch_cond_i) begin
      src = BR;
    end
  end

  always_comb begin
    next_pc_o = pc_plus4_i;
    case (src)
      JR:      next_pc_o = jr_addr_i;
      J:       next_pc_o = jumpTarget;
      BR:      next_pc_o = branchTarget;
      default: next_pc_o = pc_plus4_i;
    endcase
  end

  assign redirect_o = (src != SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with BOOT/RUN/HALT control and a saturating redirect counter.
// Optional misalignment trap enabled by defining PC_SEQ_MISALIGN_CHECK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             branch_i,
  input  logic             branch_cond_i,
  input  logic [31:0]      offset_sh2_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_idx_i,
  input  logic             jr_i,
  input  logic [31:0]      jr_addr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             pc_valid_o,
  output logic             redirect_o,
  output logic [CNT_W-1:0] redirect_cnt_o
`ifdef PC_SEQ_MISALIGN_CHECK_EN
  ,
  output logic             misalign_o
`endif
);

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      nextPc;
  logic             srcRedirect;
  logic             takeExc;

  assign pc_plus4_o = pc_q + PC_INCR;

  pc_next_mux u_next_mux (
    .pc_plus4_i    (pc_plus4_o),
    .branch_i      (branch_i),
    .branch_cond_i (branch_cond_i),
    .offset_sh2_i  (offset_sh2_i),
    .jump_i        (jump_i),
    .jump_idx_i    (jump_idx_i),
    .jr_i          (jr_i),
    .jr_addr_i     (jr_addr_i),
    .next_pc_o     (nextPc),
    .redirect_o    (srcRedirect)
  );

  // Without the trap, a misaligned target is silently word-aligned instead.
  assign takeExc = CheckEn && srcRedirect && (nextPc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pc_valid_o = 1'b0;
    redirect_o = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        pc_valid_o = 1'b1;
        redirect_o = srcRedirect;
        if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          pc_d = takeExc ? EXC_VECTOR : (nextPc & ALIGN_MASK);
          if (srcRedirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HALT: begin
        if (resume_i && !halt_i) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle pulse that lines up with EXC_VECTOR appearing on pc_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_q == RUN) && !halt_i && !stall_i && takeExc;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign pc_o           = pc_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps push expected outputs, a monitor compares.
module tb_pc_sequencer;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        br;
    logic        cond;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jra;
  } ctl_t;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        valid;
    logic        redir;
    logic [15:0] cnt;
    logic [1:0]  sat;
    logic        mis;
  } exp_t;

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  localparam logic [31:0] MisPc = 32'h0000_0080;
  localparam logic        MisOn = 1'b1;
`else
  localparam logic [31:0] MisPc = 32'h0000_0040;
  localparam logic        MisOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic        br = 1'b0, cond = 1'b0, jmp = 1'b0, jr = 1'b0;
  logic [31:0] off = '0, jra = '0;
  logic [25:0] idx = '0;
  logic [31:0] pc, pcPlus4, pcSat, pcPlus4Sat;
  logic        valid, redir, validSat, redirSat;
  logic [15:0] cnt;
  logic [1:0]  cntSat;
  logic        mis;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .branch_i(br), .branch_cond_i(cond), .offset_sh2_i(off), .jump_i(jmp),
    .jump_idx_i(idx), .jr_i(jr), .jr_addr_i(jra), .pc_o(pc), .pc_plus4_o(pcPlus4),
    .pc_valid_o(valid), .redirect_o(redir), .redirect_cnt_o(cnt)
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    , .misalign_o(mis)
`endif
  );

  logic misSat;
  pc_sequencer #(.CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .branch_i(br), .branch_cond_i(cond), .offset_sh2_i(off), .jump_i(jmp),
    .jump_idx_i(idx), .jr_i(jr), .jr_addr_i(jra), .pc_o(pcSat), .pc_plus4_o(pcPlus4Sat),
    .pc_valid_o(validSat), .redirect_o(redirSat), .redirect_cnt_o(cntSat)
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    , .misalign_o(misSat)
`endif
  );

`ifndef PC_SEQ_MISALIGN_CHECK_EN
  assign mis    = 1'b0;
  assign misSat = 1'b0;
`endif

  function automatic ctl_t mkCtl(logic r, logic s, logic h, logic re, logic b, logic c,
                                 logic [31:0] o, logic j, logic [25:0] ix, logic jrr,
                                 logic [31:0] ja);
    ctl_t t;
    t.rst = r; t.stall = s; t.halt = h; t.resume = re; t.br = b; t.cond = c;
    t.off = o; t.jmp = j; t.idx = ix; t.jr = jrr; t.jra = ja;
    return t;
  endfunction

  function automatic exp_t mkExp(logic [31:0] p, logic v, logic rd, logic [15:0] c, logic m);
    exp_t e;
    e.step = 0; e.pc = p; e.valid = v; e.redir = rd; e.cnt = c; e.mis = m;
    e.sat = (c > 16'd3) ? 2'd3 : c[1:0];
    return e;
  endfunction

  // Drive one cycle's controls just after the edge and queue what the outputs must show.
  task automatic applyStimulus(input ctl_t c, input exp_t e);
    @(posedge clk);
    #2;
    rst = c.rst; stall = c.stall; halt = c.halt; resume = c.resume;
    br = c.br; cond = c.cond; off = c.off; jmp = c.jmp; idx = c.idx; jr = c.jr; jra = c.jra;
    e.step = stepNo;
    stepNo++;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (pc !== e.pc || pcPlus4 !== (e.pc + 32'd4) || valid !== e.valid ||
        redir !== e.redir || cnt !== e.cnt || cntSat !== e.sat || pcSat !== e.pc ||
        (MisOn && mis !== e.mis)) begin
      errors++;
      $display("[TB] FAIL step%0d: got pc=%h p4=%h v=%b rd=%b cnt=%0d sat=%0d mis=%b; want pc=%h p4=%h v=%b rd=%b cnt=%0d sat=%0d mis=%b",
               e.step, pc, pcPlus4, valid, redir, cnt, cntSat, mis,
               e.pc, e.pc + 32'd4, e.valid, e.redir, e.cnt, e.sat, e.mis);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    // Reset, boot and sequential fetch.
    applyStimulus(mkCtl(1,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 0, 0, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 0, 0, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 1, 0, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h4, 1, 0, 0, 0));
    // Branch taken / not taken around 0x100.
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h100), mkExp(32'h8, 1, 1, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,1,1,32'hFFFF_FFF0,0,0,0,0), mkExp(32'h100, 1, 1, 1, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h100), mkExp(32'hF4, 1, 1, 2, 0));
    applyStimulus(mkCtl(0,0,0,0,1,0,32'hFFFF_FFF0,0,0,0,0), mkExp(32'h100, 1, 0, 3, 0));
    // jr beats jump; then jump alone keeps the PC+4 top nibble.
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h3000_0000), mkExp(32'h104, 1, 1, 3, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,1,26'h10,1,32'h40), mkExp(32'h3000_0000, 1, 1, 4, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h3000_0000), mkExp(32'h40, 1, 1, 5, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,1,26'h10,0,0), mkExp(32'h3000_0000, 1, 1, 6, 0));
    // Stall with a taken branch holds PC and count but still flags redirect.
    for (int i = 0; i < 3; i++)
      applyStimulus(mkCtl(0,1,0,0,1,1,32'h10,0,0,0,0), mkExp(32'h3000_0040, 1, 1, 7, 0));
    applyStimulus(mkCtl(0,0,0,0,1,1,32'h10,0,0,0,0), mkExp(32'h3000_0040, 1, 1, 7, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h3000_0054, 1, 0, 8, 0));
    // Halt beats jump, halt+resume stays halted, resume returns with same PC.
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h20), mkExp(32'h3000_0058, 1, 1, 8, 0));
    applyStimulus(mkCtl(0,0,1,0,0,0,0,1,26'h10,0,0), mkExp(32'h20, 1, 1, 9, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,1,26'h10,0,0), mkExp(32'h20, 0, 0, 9, 0));
    applyStimulus(mkCtl(0,0,1,1,0,0,0,0,0,0,0), mkExp(32'h20, 0, 0, 9, 0));
    applyStimulus(mkCtl(0,0,0,1,0,0,0,0,0,0,0), mkExp(32'h20, 0, 0, 9, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h20, 1, 0, 9, 0));
    applyStimulus(mkCtl(0,0,1,0,0,0,0,0,0,0,0), mkExp(32'h24, 1, 0, 9, 0));
    // Reset while halted.
    applyStimulus(mkCtl(1,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 0, 0, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 0, 0, 0, 0));
    // Misaligned jr target: trap to vector, or word-aligned when the trap is absent.
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'h42), mkExp(32'h0, 1, 1, 0, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(MisPc, 1, 0, 1, 1));
    // PC+4 wraps to zero at the top of the address space.
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,1,32'hFFFF_FFFC), mkExp(MisPc + 32'd4, 1, 1, 1, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'hFFFF_FFFC, 1, 0, 2, 0));
    applyStimulus(mkCtl(0,0,0,0,0,0,0,0,0,0,0), mkExp(32'h0, 1, 0, 2, 0));

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
